// File: rtl/block_stat_accum.sv
`default_nettype none
// ============================================================================
// block_stat_accum : per-block max / truncated-average statistics with row sum
// Rev 1.0
// ============================================================================
module block_stat_accum #(
  parameter int BW_LOG2  = 6,
  parameter int BL_LOG2  = 6,
  parameter int BLOCKS_H = 16
) (
  input  logic        iODCK,
  input  logic        iRST,
  input  logic [7:0]  iPixelData,
  input  logic        iH_Duty,
  input  logic        iV_Duty,
  input  logic        iSw_0Max_1Avg,
  output logic [7:0]  oBlockData,
  output logic [13:0] oLineSum,
  output logic        oEnEnha,
  output logic [5:0]  oH_Block_Count,
  output logic [6:0]  oV_Block_Duty_Count
);

  localparam int PW   = (BW_LOG2 > 0) ? BW_LOG2 : 1;
  localparam int LW   = (BL_LOG2 > 0) ? BL_LOG2 : 1;
  localparam int CW   = (BLOCKS_H > 1) ? $clog2(BLOCKS_H) : 1;
  localparam int AW   = 8 + BW_LOG2 + BL_LOG2;
  localparam int SH   = BW_LOG2 + BL_LOG2;
  localparam int NACC = 1 << CW;
  localparam logic [PW-1:0] PX_MAX  = PW'((1 << BW_LOG2) - 1);
  localparam logic [LW-1:0] LN_MAX  = LW'((1 << BL_LOG2) - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(BLOCKS_H - 1);
  localparam logic [6:0]    ROW_MAX = 7'd127;

  logic [PW-1:0] px_q, px_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] ln_q, ln_d;
  logic [6:0]    row_q, row_d;
  logic          done_q, done_d;
  logic          mode_q, mode_d;
  logic          h_prev_q, h_prev_d;
  logic          v_prev_q, v_prev_d;
  logic [AW-1:0] acc_q [NACC];
  logic [AW-1:0] acc_d [NACC];
  logic [13:0]   run_q, run_d;
  logic [13:0]   sum_q, sum_d;
  logic          en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic [5:0]    hcnt_q, hcnt_d;
  logic [6:0]    vcnt_q, vcnt_d;

  logic          v_rise, h_fall, active, last_px, finalise;
  logic [AW-1:0] acc_cur, pix_ext, acc_sum, pix_max;
  logic [7:0]    value;

  always_comb begin
    v_rise   = iV_Duty & ~v_prev_q;
    h_fall   = h_prev_q & ~iH_Duty;
    // done_q masks pixels past the last block until the line ends
    active   = iH_Duty & iV_Duty & ~done_q;
    last_px  = (px_q == PX_MAX);
    finalise = active & last_px & (ln_q == LN_MAX);
    acc_cur  = acc_q[col_q];
    pix_ext  = AW'(iPixelData);
    acc_sum  = acc_cur + pix_ext;
    pix_max  = (acc_cur > pix_ext) ? acc_cur : pix_ext;
    value    = mode_q ? 8'(acc_sum >> SH) : 8'(pix_max);

    px_d     = px_q;
    col_d    = col_q;
    ln_d     = ln_q;
    row_d    = row_q;
    done_d   = done_q;
    mode_d   = mode_q;
    h_prev_d = iH_Duty;
    v_prev_d = iV_Duty;
    acc_d    = acc_q;
    run_d    = run_q;
    sum_d    = sum_q;
    en_d     = 1'b0;
    data_d   = data_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;

    if (v_rise) begin
      px_d   = '0;
      col_d  = '0;
      ln_d   = '0;
      row_d  = '0;
      done_d = 1'b0;
      mode_d = iSw_0Max_1Avg;
      run_d  = '0;
      for (int i = 0; i < NACC; i++) acc_d[i] = '0;
    end else begin
      if (active) begin
        if (finalise) begin
          acc_d[col_q] = '0;
          en_d         = 1'b1;
          data_d       = value;
          hcnt_d       = 6'(col_q);
          vcnt_d       = row_q;
          if (col_q == COL_MAX) begin
            sum_d = run_q + 14'(value);
            run_d = '0;
          end else begin
            run_d = run_q + 14'(value);
          end
        end else begin
          acc_d[col_q] = mode_q ? acc_sum : pix_max;
        end
        px_d = last_px ? '0 : px_q + PW'(1);
        if (last_px) begin
          if (col_q == COL_MAX) done_d = 1'b1;
          else                  col_d  = col_q + CW'(1);
        end
      end
      // Only a line that reached the end of the last block counts toward ln
      if (h_fall) begin
        px_d   = '0;
        col_d  = '0;
        done_d = 1'b0;
        if (done_q) begin
          ln_d = (ln_q == LN_MAX) ? '0 : ln_q + LW'(1);
          if (ln_q == LN_MAX && row_q != ROW_MAX) row_d = row_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      px_q     <= '0;
      col_q    <= '0;
      ln_q     <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
      h_prev_q <= 1'b0;
      v_prev_q <= 1'b0;
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      run_q    <= '0;
      sum_q    <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
    end else begin
      px_q     <= px_d;
      col_q    <= col_d;
      ln_q     <= ln_d;
      row_q    <= row_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      h_prev_q <= h_prev_d;
      v_prev_q <= v_prev_d;
      acc_q    <= acc_d;
      run_q    <= run_d;
      sum_q    <= sum_d;
      en_q     <= en_d;
      data_q   <= data_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
    end
  end

  assign oBlockData          = data_q;
  assign oLineSum            = sum_q;
  assign oEnEnha             = en_q;
  assign oH_Block_Count      = hcnt_q;
  assign oV_Block_Duty_Count = vcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_block_stat_accum.sv
`default_nettype none
// ============================================================================
// tb_block_stat_accum : randomized bench with an image-level reference model
// Rev 1.0
// ============================================================================
module tb_block_stat_accum;

  localparam int BW_LOG2  = 2;
  localparam int BL_LOG2  = 1;
  localparam int BLOCKS_H = 3;
  localparam int BWID     = 1 << BW_LOG2;
  localparam int BLH      = 1 << BL_LOG2;
  localparam int LINE_PIX = BWID * BLOCKS_H;
  localparam int SH       = BW_LOG2 + BL_LOG2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  pix = '0;
  logic        h = 1'b0, v = 1'b0, sw = 1'b0;
  logic [7:0]  o_data;
  logic [13:0] o_sum;
  logic        o_en;
  logic [5:0]  o_h;
  logic [6:0]  o_v;

  block_stat_accum #(.BW_LOG2(BW_LOG2), .BL_LOG2(BL_LOG2), .BLOCKS_H(BLOCKS_H)) dut (
    .iODCK(clk), .iRST(rst_n), .iPixelData(pix), .iH_Duty(h), .iV_Duty(v),
    .iSw_0Max_1Avg(sw), .oBlockData(o_data), .oLineSum(o_sum), .oEnEnha(o_en),
    .oH_Block_Count(o_h), .oV_Block_Duty_Count(o_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  // reference model: per-frame block sums/maxima, counted lines, row index
  bit m_mode;
  int m_ln, m_row, m_run;
  int blk_sum [BLOCKS_H];
  int blk_max [BLOCKS_H];
  bit exp_en;
  int exp_data, exp_h, exp_v, exp_sum;
  bit nx_en;
  int nx_val, nx_col, nx_row;
  bit chk_on = 1'b0;
  int dut_strobes = 0;
  int line_buf [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("strobe", 32'(o_en), 32'(exp_en));
      check("block_data", 32'(o_data), exp_data);
      check("h_block", 32'(o_h), exp_h);
      check("v_block", 32'(o_v), exp_v);
      check("line_sum", 32'(o_sum), exp_sum);
      if (o_en === 1'b1) dut_strobes++;
    end
  end

  task automatic model_clear();
    m_ln = 0; m_row = 0; m_run = 0;
    for (int c = 0; c < BLOCKS_H; c++) begin blk_sum[c] = 0; blk_max[c] = 0; end
  endtask

  task automatic tick(input logic hh, input logic vv, input logic [7:0] p);
    h = hh; v = vv; pix = p;
    @(posedge clk);
    exp_en = nx_en;
    if (nx_en) begin
      exp_data = nx_val; exp_h = nx_col; exp_v = nx_row;
      if (nx_col == BLOCKS_H - 1) begin exp_sum = m_run + nx_val; m_run = 0; end
      else m_run += nx_val;
    end
    nx_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_frame(input bit mode);
    tick(0, 0, 0);
    tick(0, 0, 0);
    sw = mode;
    tick(0, 1, 0);
    m_mode = mode;
    model_clear();
    tick(0, 1, 0);
  endtask

  task automatic drive_line(input int n, input int blank);
    for (int i = 0; i < n; i++) begin
      if (i < LINE_PIX) begin
        int c;
        c = i / BWID;
        blk_sum[c] += line_buf[i];
        if (line_buf[i] > blk_max[c]) blk_max[c] = line_buf[i];
        if (m_ln == BLH - 1 && (i % BWID) == BWID - 1) begin
          nx_en  = 1'b1;
          nx_val = m_mode ? ((blk_sum[c] >> SH) & 255) : blk_max[c];
          nx_col = c;
          nx_row = m_row;
          blk_sum[c] = 0; blk_max[c] = 0;
        end
      end
      tick(1, 1, 8'(line_buf[i]));
    end
    for (int b = 0; b < blank; b++) tick(0, 1, 0);
    if (n >= LINE_PIX) begin
      m_ln++;
      if (m_ln == BLH) begin
        m_ln = 0;
        if (m_row < 127) m_row++;
      end
    end
  endtask

  task automatic fill(input int kind, input int val);
    for (int i = 0; i < 64; i++) line_buf[i] = (kind == 0) ? val : int'($urandom_range(0, 255));
    for (int i = LINE_PIX; i < 64; i++) line_buf[i] = 255;
  endtask

  task automatic run_rows(input int nrows, input int val, input int excess);
    for (int l = 0; l < nrows * BLH; l++) begin
      fill(0, val);
      drive_line(LINE_PIX + excess, 2);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_strobe", 32'(o_en), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_sum", 32'(o_sum), 0);
    check("rst_h", 32'(o_h), 0);
    check("rst_v", 32'(o_v), 0);
    exp_en = 0; exp_data = 0; exp_h = 0; exp_v = 0; exp_sum = 0; nx_en = 0;
    m_mode = 0;
    model_clear();
    h = 0; v = 0; pix = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    exp_en = 0; exp_data = 0; exp_h = 0; exp_v = 0; exp_sum = 0; nx_en = 0;
    m_mode = 0;
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    check("init_strobe", 32'(o_en), 0);
    check("init_sum", 32'(o_sum), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Average mode, two block rows of constant 100
    start_frame(1);
    s0 = dut_strobes;
    run_rows(2, 100, 0);
    check("avg100_data", 32'(o_data), 100);
    check("avg100_sum", 32'(o_sum), 300);
    check("avg100_row", 32'(o_v), 1);
    check("avg100_col", 32'(o_h), BLOCKS_H - 1);
    check("avg100_count", dut_strobes - s0, 2 * BLOCKS_H);
    check("model_pin_sum", exp_sum, 300);

    // Max mode, a single 250 in row 0, column 1
    start_frame(0);
    fill(0, 10);
    line_buf[BWID + 1] = 250;
    drive_line(LINE_PIX, 2);
    fill(0, 10);
    drive_line(LINE_PIX, 2);
    check("max_row0_sum", 32'(o_sum), 270);
    run_rows(1, 10, 0);
    check("max_row1_sum", 32'(o_sum), 30);
    check("max_row1_data", 32'(o_data), 10);

    // Average with mixed block contents: 15>>3=1, 3, 10
    start_frame(1);
    fill(0, 2); line_buf[0] = 1;
    for (int i = BWID; i < 2 * BWID; i++) line_buf[i] = 3;
    for (int i = 2 * BWID; i < LINE_PIX; i++) line_buf[i] = 10;
    drive_line(LINE_PIX, 2);
    line_buf[0] = 2;
    drive_line(LINE_PIX, 2);
    check("mix_sum", 32'(o_sum), 14);
    check("mix_data", 32'(o_data), 10);

    // Excess pixels after each full line change nothing
    start_frame(1);
    s0 = dut_strobes;
    run_rows(2, 100, 5);
    check("excess_sum", 32'(o_sum), 300);
    check("excess_count", dut_strobes - s0, 2 * BLOCKS_H);
    check("excess_col", 32'(o_h), BLOCKS_H - 1);

    // Frame aborted mid block row, then a clean frame of 50s
    start_frame(1);
    fill(0, 77);
    drive_line(LINE_PIX, 2);
    start_frame(1);
    run_rows(1, 50, 0);
    check("abort_data", 32'(o_data), 50);
    check("abort_row", 32'(o_v), 0);
    check("abort_sum", 32'(o_sum), 150);

    // Mode change mid-frame is ignored: avg of 0s and 200s is 100
    start_frame(1);
    fill(0, 0);
    drive_line(LINE_PIX, 2);
    sw = 1'b0;
    fill(0, 200);
    drive_line(LINE_PIX, 2);
    check("toggle_data", 32'(o_data), 100);
    check("toggle_sum", 32'(o_sum), 300);

    // Asynchronous reset mid-frame, then a full frame
    start_frame(0);
    fill(0, 9);
    drive_line(LINE_PIX, 2);
    do_reset();
    start_frame(1);
    run_rows(1, 50, 0);
    check("post_rst_sum", 32'(o_sum), 150);

    // Row index saturates at 127
    start_frame(1);
    run_rows(130, 7, 0);
    check("row_sat", 32'(o_v), 127);
    check("row_sat_sum", 32'(o_sum), 21);

    // Randomized frames: short lines, excess pixels, mid-frame switch noise
    for (int f = 0; f < 12; f++) begin
      int nlines;
      start_frame(1'($urandom));
      nlines = $urandom_range(1, 4 * BLH);
      for (int l = 0; l < nlines; l++) begin
        int n;
        fill(1, 0);
        if ($urandom_range(0, 7) == 0) n = $urandom_range(1, LINE_PIX - 1);
        else n = LINE_PIX + $urandom_range(0, 5);
        if ($urandom_range(0, 3) == 0) sw = 1'($urandom);
        drive_line(n, $urandom_range(1, 3));
      end
    end
    tick(0, 0, 0);
    tick(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/block_stat_accum.md
Name: block_stat_accum

Overview:
Upstream statistics stage for the dimming path. It accumulates the incoming pixel stream into a grid of rectangular backlight blocks and computes one 8-bit value per block, either the maximum or the truncated average. Each value is emitted with a one-cycle write strobe, together with the sum of block values for the last completed block row. The outputs feed the enhancement stage's write-enable, block-data and line-sum inputs.

Parameters:
BW_LOG2, 6, log2 of pixels per block horizontally (block width 64).
BL_LOG2, 6, log2 of lines per block vertically (block height 64).
BLOCKS_H, 16, blocks per line; legal range 1..64.

Ports:
iODCK  in  1  pixel clock; all logic on its rising edge.
iRST  in  1  asynchronous reset, active-low.
iPixelData  in  8  pixel luminance; valid when iH_Duty=1 and iV_Duty=1.
iH_Duty  in  1  active-line window.
iV_Duty  in  1  active-frame window.
iSw_0Max_1Avg  in  1  statistic select: 0 = max, 1 = average.
oBlockData  out  8  block value, valid while oEnEnha=1.
oLineSum  out  14  sum of all BLOCKS_H values of the last completed block row.
oEnEnha  out  1  one-cycle strobe per finished block.
oH_Block_Count  out  6  column index of the block being strobed.
oV_Block_Duty_Count  out  7  row index of the block being strobed.

Behaviour:
- Reset (iRST=0, async): all outputs are 0. Counters, per-column accumulators, the running row sum and the mode latch are cleared.
- Mode latch: iSw_0Max_1Avg is sampled on the iV_Duty rising edge. Changes mid-frame are ignored.
- Counters:
  - px: 0..2^BW_LOG2-1, counts active pixels within a block.
  - col: 0..BLOCKS_H-1.
  - ln: 0..2^BL_LOG2-1, line within the block row.
  - row: 0..127, saturating.
  - px and col advance on each active pixel. px wraps and col increments at px=max.
- Excess pixels: active pixels after col=BLOCKS_H-1, px=max are ignored until iH_Duty falls.
- Line end (iH_Duty falling edge):
  - px and col return to 0.
  - ln increments only if the line reached the end of the last block.
  - A short line leaves partial data in place; the counters still reset.
- Block-row end: when ln wraps at max, row increments, saturating at 127.
- Accumulators: one per column.
  - Average mode: acc[col] += pixel, width 8+BW_LOG2+BL_LOG2 bits, no overflow possible.
  - Max mode: acc[col] = max(acc[col], pixel).
- Finalise, on the active pixel where ln=max and px=max:
  - Average mode: value = (acc[col]+pixel) >> (BW_LOG2+BL_LOG2), truncating.
  - Max mode: value = max(acc[col], pixel).
  - acc[col] is cleared in the same cycle.
- Output latency: exactly 1 cycle after the finalising pixel.
  - oEnEnha=1 for one cycle; oBlockData=value.
  - oH_Block_Count=col and oV_Block_Duty_Count=row are registered with the strobe.
  - Between strobes these outputs hold their last values.
- Row sum:
  - A running 14-bit sum adds each strobed value.
  - On the col=BLOCKS_H-1 strobe, oLineSum <= running+value (same cycle as that strobe) and running clears.
  - oLineSum otherwise holds its value. Maximum 64*255 = 16320, so no overflow.
- Frame boundaries:
  - iV_Duty rising: px, col, ln, row, accumulators and running sum are cleared; oLineSum holds.
  - iV_Duty falling mid block row: no strobes for the incomplete row; that data is discarded at the next rising edge.
- Simultaneous iH_Duty fall with the last pixel: that pixel is processed first, then the line-end reset applies.
- Back-to-back strobes: with BW_LOG2=0 a strobe may occur on every cycle. No stalls, no backpressure.

Test Plan:
- Defaults, average mode, two full block rows of constant pixel 100 -> 32 strobes, each oBlockData=100. oLineSum=1600 after strobes col15/row0 and col15/row1. Row indices 0 then 1.
- Max mode, frame of 10s with a single 250 at row0, col3 -> strobe col3=250, all others 10. oLineSum=400.
- BW_LOG2=1, BL_LOG2=1, BLOCKS_H=2, average mode, block0 pixels 1,2 / 2,2 and block1 pixels 3,3 / 3,3 -> values 1 and 3. Strobes exactly 1 cycle after the last pixel. oLineSum=4.
- Defaults, 32 extra pixels of 255 after each full line -> values identical to the scenario without them. No extra strobes; col never exceeds 15.
- iV_Duty dropped after 40 lines of a block row, then a fresh frame of 50s -> no strobes in the aborted frame. The new frame yields 50s with row starting at 0.
- iRST pulsed low mid-frame, plus iSw_0Max_1Avg toggled mid-frame in a separate run -> outputs read 0 immediately without a clock edge. The next full frame is correct. The toggle has no effect until the next frame.
